vault_door_ctrl: RTL and testbench

VAULT_DOOR_CTRL -- requirements
Module: vault_door_ctrl

---
 rtl/vault_door_if.sv | 28 ++
 rtl/vault_door_ctrl.sv | 132 +++++++++++++
 tb/tb_vault_door_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vault_door_if.sv
// Signal bundle between the vault door controller, the vault sequencer and the door motor/sensor.
// The master side is the controller; the slave side is its environment.
interface vault_door_if;
   logic       vault_done;
   logic       vault_fail;
   logic       door_ack;
   logic       door_closed;
   logic       door_open_req;
   logic       door_unlocked;
   logic       door_ajar;
   logic       lockout;
   logic       alarm;
   logic       vault_rearm;
   logic [1:0] fail_count;
   logic [2:0] state_out;

   modport master (
      input  vault_done, vault_fail, door_ack, door_closed,
      output door_open_req, door_unlocked, door_ajar, lockout, alarm,
             vault_rearm, fail_count, state_out
   );

   modport slave (
      output vault_done, vault_fail, door_ack, door_closed,
      input  door_open_req, door_unlocked, door_ajar, lockout, alarm,
             vault_rearm, fail_count, state_out
   );
endinterface

// File: rtl/vault_door_ctrl.sv
// Vault door controller: turns vault sequencer results into door unlock/relock sequencing,
// counts failed attempts with lockout, and latches a fault alarm on motor ack timeout.
module vault_door_ctrl #(
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int ACK_TIMEOUT    = 8,
   parameter int OPEN_HOLD      = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   vault_door_if.master bus
);

   typedef enum logic [2:0] {
      LOCKED    = 3'd0,
      UNLOCKING = 3'd1,
      OPEN      = 3'd2,
      RELOCK    = 3'd3,
      LOCKOUT   = 3'd4,
      FAULT     = 3'd5
   } state_t;

   localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAILS);
   localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(OPEN_HOLD - 1);
   localparam logic [7:0] HOLD_DONE  = 8'(OPEN_HOLD);
   localparam logic [7:0] LOCK_LAST  = 8'(LOCKOUT_CYCLES - 1);

   state_t     state, next_state;
   logic [7:0] timer, timer_next;
   logic [1:0] fail_cnt, fail_cnt_next;
   logic       done_p0, done_p1, fail_p0, fail_p1;
   logic       done_edge, fail_edge;
   logic       open_req, unlocked, lockout_r, alarm_r, rearm;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? 2'd3 : c + 2'd1;
   endfunction

   // Stage p0 samples the raw levels; stage p1 holds the previous sample for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_p0 <= 1'b0;
         done_p1 <= 1'b0;
         fail_p0 <= 1'b0;
         fail_p1 <= 1'b0;
      end else begin
         done_p0 <= bus.vault_done;
         done_p1 <= done_p0;
         fail_p0 <= bus.vault_fail;
         fail_p1 <= fail_p0;
      end
   end

   assign done_edge = done_p0 & ~done_p1;
   assign fail_edge = fail_p0 & ~fail_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOCKED;
         timer     <= '0;
         fail_cnt  <= '0;
         open_req  <= 1'b0;
         unlocked  <= 1'b0;
         lockout_r <= 1'b0;
         alarm_r   <= 1'b0;
         rearm     <= 1'b0;
      end else begin
         state     <= next_state;
         timer     <= timer_next;
         fail_cnt  <= fail_cnt_next;
         open_req  <= (next_state == UNLOCKING);
         unlocked  <= (next_state == OPEN);
         lockout_r <= (next_state == LOCKOUT);
         alarm_r   <= (next_state == FAULT);
         rearm     <= (next_state == RELOCK);
      end
   end

   // A fail edge always wins over a coincident done edge; edges seen outside LOCKED are dropped
   always_comb begin
      next_state    = state;
      timer_next    = timer;
      fail_cnt_next = fail_cnt;
      case (state)
         LOCKED: begin
            if (fail_edge) begin
               fail_cnt_next = sat_inc(fail_cnt);
               if (sat_inc(fail_cnt) == FAIL_LIMIT) next_state = LOCKOUT;
            end else if (done_edge) begin
               next_state = UNLOCKING;
            end
         end
         UNLOCKING: begin
            if (bus.door_ack)          next_state = OPEN;
            else if (timer >= ACK_LAST) next_state = FAULT;
         end
         OPEN: begin
            if ((timer >= HOLD_LAST) && bus.door_closed) next_state = RELOCK;
         end
         RELOCK:  next_state = LOCKED;
         LOCKOUT: begin
            if (timer >= LOCK_LAST) next_state = RELOCK;
         end
         FAULT:   next_state = FAULT;
         default: next_state = FAULT;
      endcase

      // Timer parks at OPEN_HOLD in OPEN so door_ajar can be decoded from it
      if (next_state != state) begin
         timer_next = '0;
      end else if ((state == UNLOCKING) || (state == LOCKOUT) ||
                   ((state == OPEN) && (timer != HOLD_DONE))) begin
         timer_next = timer + 8'd1;
      end

      if (next_state == RELOCK) fail_cnt_next = '0;
   end

   assign bus.state_out     = state;
   assign bus.door_ajar     = (state == OPEN) && (timer == HOLD_DONE);
   assign bus.door_open_req = open_req;
   assign bus.door_unlocked = unlocked;
   assign bus.lockout       = lockout_r;
   assign bus.alarm         = alarm_r;
   assign bus.vault_rearm   = rearm;
   assign bus.fail_count    = fail_cnt;

   a_outputs_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({open_req, unlocked, lockout_r, alarm_r, rearm}));

endmodule

// File: tb/tb_vault_door_ctrl.sv
// Directed bench for vault_door_ctrl: unlock/relock, lockout, ack timeout fault, ajar and reset behaviour.
module tb_vault_door_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          tests = 0;
   int          fails = 0;
   logic [10:0] obs;
   logic [10:0] expv;

   vault_door_if bus ();

   vault_door_ctrl #(
      .MAX_FAILS(3), .LOCKOUT_CYCLES(16), .ACK_TIMEOUT(8), .OPEN_HOLD(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // {state, fail_count, open_req, unlocked, ajar, lockout, alarm, rearm}
   assign obs = {bus.state_out, bus.fail_count, bus.door_open_req, bus.door_unlocked,
                 bus.door_ajar, bus.lockout, bus.alarm, bus.vault_rearm};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.vault_done = 1'b0;
      bus.vault_fail = 1'b0;
      bus.door_ack = 1'b0;
      bus.door_closed = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.vault_done = 1'b0;
      bus.vault_fail = 1'b0;
      bus.door_ack = 1'b0;
      bus.door_closed = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL reset_state: got %b want %b", obs, expv); fails++; end
      tests++;
      apply_reset();
   endtask

   task automatic test_first_edge();
      rst_n = 1'b0;
      bus.vault_done = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL first_edge_clk1: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      expv = {3'd1, 2'd0, 6'b100000};
      if (obs !== expv) begin $display("FAIL first_edge_clk2: got %b want %b", obs, expv); fails++; end
      tests++;
      apply_reset();
   endtask

   task automatic test_open_cycle();
      bus.vault_done = 1'b1;
      tick();
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL open_sample: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      for (int i = 0; i < 3; i++) begin
         expv = {3'd1, 2'd0, 6'b100000};
         if (obs !== expv) begin $display("FAIL open_unlocking c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         if (i == 2) bus.door_ack = 1'b1;
         tick();
      end
      bus.door_ack = 1'b0;
      bus.vault_done = 1'b0;
      bus.door_closed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         expv = {3'd2, 2'd0, 6'b010000};
         if (obs !== expv) begin $display("FAIL open_hold c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         tick();
      end
      expv = {3'd3, 2'd0, 6'b000001};
      if (obs !== expv) begin $display("FAIL open_relock: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL open_back_locked: got %b want %b", obs, expv); fails++; end
      tests++;
      bus.door_closed = 1'b0;
   endtask

   task automatic test_lockout();
      for (int k = 1; k <= 3; k++) begin
         bus.vault_fail = 1'b1;
         tick();
         bus.vault_fail = 1'b0;
         tick();
         expv = (k < 3) ? {3'd0, 2'(k), 6'b000000} : {3'd4, 2'd3, 6'b000100};
         if (obs !== expv) begin $display("FAIL lockout_fail%0d: got %b want %b", k, obs, expv); fails++; end
         tests++;
      end
      for (int i = 0; i < 16; i++) begin
         expv = {3'd4, 2'd3, 6'b000100};
         if (obs !== expv) begin $display("FAIL lockout_hold c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         if (i == 3)  bus.vault_done = 1'b1;
         if (i == 6)  bus.vault_done = 1'b0;
         if (i == 9)  bus.vault_fail = 1'b1;
         if (i == 11) bus.vault_fail = 1'b0;
         tick();
      end
      expv = {3'd3, 2'd0, 6'b000001};
      if (obs !== expv) begin $display("FAIL lockout_relock: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      tick();
      tick();
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL lockout_no_queue: got %b want %b", obs, expv); fails++; end
      tests++;
   endtask

   task automatic test_simultaneous();
      bus.vault_done = 1'b1;
      bus.vault_fail = 1'b1;
      tick();
      bus.vault_done = 1'b0;
      bus.vault_fail = 1'b0;
      tick();
      expv = {3'd0, 2'd1, 6'b000000};
      if (obs !== expv) begin $display("FAIL simul_count: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      tick();
      expv = {3'd0, 2'd1, 6'b000000};
      if (obs !== expv) begin $display("FAIL simul_stays_locked: got %b want %b", obs, expv); fails++; end
      tests++;
      apply_reset();
   endtask

   task automatic test_ack_boundary();
      bus.vault_done = 1'b1;
      tick();
      tick();
      bus.vault_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) bus.door_ack = 1'b1;
         tick();
      end
      bus.door_ack = 1'b0;
      expv = {3'd2, 2'd0, 6'b010000};
      if (obs !== expv) begin $display("FAIL ack_last_cycle: got %b want %b", obs, expv); fails++; end
      tests++;
      bus.door_closed = 1'b1;
      repeat (9) tick();
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL ack_last_return: got %b want %b", obs, expv); fails++; end
      tests++;
      bus.door_closed = 1'b0;
   endtask

   task automatic test_ajar();
      bus.vault_done = 1'b1;
      tick();
      tick();
      bus.door_ack = 1'b1;
      tick();
      bus.door_ack = 1'b0;
      bus.vault_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expv = {3'd2, 2'd0, 6'b010000};
         if (obs !== expv) begin $display("FAIL ajar_hold c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         expv = {3'd2, 2'd0, 6'b011000};
         if (obs !== expv) begin $display("FAIL ajar_open c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         tick();
      end
      bus.door_closed = 1'b1;
      tick();
      expv = {3'd3, 2'd0, 6'b000001};
      if (obs !== expv) begin $display("FAIL ajar_relock: got %b want %b", obs, expv); fails++; end
      tests++;
      tick();
      bus.door_closed = 1'b0;
   endtask

   task automatic test_fault();
      bus.vault_done = 1'b1;
      tick();
      tick();
      bus.vault_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expv = {3'd1, 2'd0, 6'b100000};
         if (obs !== expv) begin $display("FAIL fault_wait c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
         tick();
      end
      expv = {3'd5, 2'd0, 6'b000010};
      if (obs !== expv) begin $display("FAIL fault_entry: got %b want %b", obs, expv); fails++; end
      tests++;
      bus.vault_done = 1'b1;
      tick();
      bus.vault_done = 1'b0;
      bus.door_ack = 1'b1;
      tick();
      tick();
      bus.door_ack = 1'b0;
      expv = {3'd5, 2'd0, 6'b000010};
      if (obs !== expv) begin $display("FAIL fault_sticky: got %b want %b", obs, expv); fails++; end
      tests++;
      #2 rst_n = 1'b0;
      #1;
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL fault_reset: got %b want %b", obs, expv); fails++; end
      tests++;
      #3 rst_n = 1'b1;
   endtask

   task automatic test_reset_open();
      bus.vault_done = 1'b1;
      tick();
      tick();
      bus.door_ack = 1'b1;
      tick();
      bus.door_ack = 1'b0;
      bus.vault_done = 1'b0;
      bus.door_closed = 1'b1;
      tick();
      tick();
      expv = {3'd2, 2'd0, 6'b010000};
      if (obs !== expv) begin $display("FAIL rst_open_pre: got %b want %b", obs, expv); fails++; end
      tests++;
      #2 rst_n = 1'b0;
      #1;
      expv = {3'd0, 2'd0, 6'b000000};
      if (obs !== expv) begin $display("FAIL rst_open_async: got %b want %b", obs, expv); fails++; end
      tests++;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expv = {3'd0, 2'd0, 6'b000000};
         if (obs !== expv) begin $display("FAIL rst_open_after c%0d: got %b want %b", i, obs, expv); fails++; end
         tests++;
      end
      bus.door_closed = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_edge();
      test_open_cycle();
      test_lockout();
      test_simultaneous();
      test_ack_boundary();
      test_ajar();
      test_fault();
      test_reset_open();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
